// File: rtl/pipe_scroller_if.sv
// Control inputs and world-state outputs of the pipe scroller.
interface pipe_scroller_if;
  logic        tick;
  logic        run;
  logic [2:0]  speed;
  logic [49:0] X_Edge_L;
  logic [49:0] X_Edge_R;
  logic [49:0] Y_Edge_Top;
  logic [49:0] Y_Edge_Bottom;
  logic [49:0] X_Coin_L;
  logic [49:0] X_Coin_R;
  logic [49:0] Y_Coin;
  logic        shift_Coin;
  logic        score_pulse;
  logic [15:0] lfsr_out;

  modport master (
    output tick, run, speed,
    input  X_Edge_L, X_Edge_R, Y_Edge_Top, Y_Edge_Bottom,
    input  X_Coin_L, X_Coin_R, Y_Coin, shift_Coin, score_pulse, lfsr_out
  );

  modport slave (
    input  tick, run, speed,
    output X_Edge_L, X_Edge_R, Y_Edge_Top, Y_Edge_Bottom,
    output X_Coin_L, X_Coin_R, Y_Coin, shift_Coin, score_pulse, lfsr_out
  );
endinterface

// File: rtl/pipe_scroller.sv
// Five-slot pipe world generator: scrolls pipes leftwards, recycles the slot
// that leaves the field to behind the rightmost one with a pseudo-random gap,
// and publishes clamped pipe/coin coordinates plus recycle/score pulses.
module pipe_scroller #(
  parameter int unsigned SCREEN_L = 155,
  parameter int unsigned SCREEN_R = 485,
  parameter int unsigned PIPE_W   = 40,
  parameter int unsigned SPACING  = 80,
  parameter int unsigned GAP_H    = 120,
  parameter int unsigned GAP_MIN  = 60,
  parameter int unsigned COIN_W   = 20,
  parameter int unsigned BIRD_X_L = 200,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic            clk_100MHz,
  input logic            rst,
  pipe_scroller_if.slave bus
);

  localparam int unsigned NSLOT = 5;
  localparam logic [10:0] L_C      = 11'(SCREEN_L);
  localparam logic [10:0] R_M1     = 11'(SCREEN_R - 1);
  localparam logic [10:0] W_M1     = 11'(PIPE_W - 1);
  localparam logic [10:0] SPC_C    = 11'(SPACING);
  localparam logic [10:0] BIRD_C   = 11'(BIRD_X_L);
  localparam logic [10:0] COIN_OFS = 11'((PIPE_W - COIN_W) / 2);
  localparam logic [10:0] COIN_M1  = 11'(COIN_W - 1);
  localparam logic [9:0]  GAP_C    = 10'(GAP_H);
  localparam logic [9:0]  GMIN_C   = 10'(GAP_MIN);
  localparam logic [9:0]  YCOIN_C  = 10'((GAP_H - COIN_W) / 2);
  localparam logic [9:0]  YT_RST   = 10'd180;

  logic [10:0] xl_q [NSLOT];
  logic [10:0] xl_d [NSLOT];
  logic [9:0]  yt_q [NSLOT];
  logic [9:0]  yt_d [NSLOT];
  logic [10:0] xr_c [NSLOT];
  logic [2:0]  rm_q, rm_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        shift_q, shift_d;
  logic        score_q, score_d;
  logic [10:0] spd;
  logic [10:0] xl_rm;
  logic        recycled;

  logic [49:0] xel, xer, yet, yeb, xcl, xcr, yc;

  function automatic logic [9:0] clamp_l(input logic [10:0] v);
    return (v < L_C) ? L_C[9:0] : v[9:0];
  endfunction

  function automatic logic [9:0] clamp_r(input logic [10:0] v);
    return (v > R_M1) ? R_M1[9:0] : v[9:0];
  endfunction

  // Raw right edges and the rightmost slot's left edge, from current state.
  always_comb begin
    xl_rm = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      xr_c[i] = xl_q[i] + W_M1;
      if (rm_q == 3'(i)) xl_rm = xl_q[i];
    end
  end

  // Next-state: LFSR advance, per-slot move/recycle and pulse generation.
  // Recycle and score tests use pre-move edges; the first recycling slot
  // wins, which is the only one possible while SPACING exceeds the max speed.
  always_comb begin
    spd      = {8'b0, bus.speed};
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    xl_d     = xl_q;
    yt_d     = yt_q;
    rm_d     = rm_q;
    shift_d  = 1'b0;
    score_d  = 1'b0;
    recycled = 1'b0;
    if (bus.tick && bus.run) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (!recycled && (xr_c[i] < L_C + spd)) begin
          xl_d[i]  = xl_rm - spd + SPC_C;
          yt_d[i]  = GMIN_C + {2'b0, lfsr_q[7:0]};
          rm_d     = 3'(i);
          shift_d  = 1'b1;
          recycled = 1'b1;
        end else begin
          xl_d[i] = xl_q[i] - spd;
        end
        if ((xr_c[i] >= BIRD_C) && (xr_c[i] < BIRD_C + spd)) score_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset to the initial pipe layout.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        xl_q[i] <= 11'(SCREEN_R + i * SPACING);
        yt_q[i] <= YT_RST;
      end
      rm_q    <= 3'd4;
      lfsr_q  <= SEED;
      shift_q <= 1'b0;
      score_q <= 1'b0;
    end else begin
      xl_q    <= xl_d;
      yt_q    <= yt_d;
      rm_q    <= rm_d;
      lfsr_q  <= lfsr_d;
      shift_q <= shift_d;
      score_q <= score_d;
    end
  end

  // Clamped draw coordinates, packed 10 bits per slot.
  always_comb begin
    xel = '0; xer = '0; yet = '0; yeb = '0; xcl = '0; xcr = '0; yc = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      xel[10*i +: 10] = clamp_l(xl_q[i]);
      xer[10*i +: 10] = clamp_r(xr_c[i]);
      yet[10*i +: 10] = yt_q[i];
      yeb[10*i +: 10] = yt_q[i] + GAP_C;
      xcl[10*i +: 10] = clamp_l(xl_q[i] + COIN_OFS);
      xcr[10*i +: 10] = clamp_r(xl_q[i] + COIN_OFS + COIN_M1);
      yc[10*i +: 10]  = yt_q[i] + YCOIN_C;
    end
  end

  assign bus.X_Edge_L      = xel;
  assign bus.X_Edge_R      = xer;
  assign bus.Y_Edge_Top    = yet;
  assign bus.Y_Edge_Bottom = yeb;
  assign bus.X_Coin_L      = xcl;
  assign bus.X_Coin_R      = xcr;
  assign bus.Y_Coin        = yc;
  assign bus.shift_Coin    = shift_q;
  assign bus.score_pulse   = score_q;
  assign bus.lfsr_out      = lfsr_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: stimulus queues expected values tagged
// with the cycle they should appear; a negedge monitor pops and compares.
module tb_pipe_scroller;

  localparam int F_XL = 0, F_XR = 1, F_YT = 2, F_YB = 3, F_CL = 4,
                 F_CR = 5, F_YC = 6, F_SH = 7, F_SC = 8, F_LF = 9;

  typedef struct {
    int    cyc;
    int    fld;
    int    slot;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   k;
  logic [15:0] m;
  logic [15:0] mv;
  exp_t q[$];
  exp_t me;
  int   ma;

  pipe_scroller_if bus();

  pipe_scroller dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lnext(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Cycle counter and reference LFSR
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m <= 16'hACE1;
    else     m <= lnext(m);
  end

  function automatic int actual(input int f, input int s);
    case (f)
      F_XL: return int'(bus.X_Edge_L[10*s +: 10]);
      F_XR: return int'(bus.X_Edge_R[10*s +: 10]);
      F_YT: return int'(bus.Y_Edge_Top[10*s +: 10]);
      F_YB: return int'(bus.Y_Edge_Bottom[10*s +: 10]);
      F_CL: return int'(bus.X_Coin_L[10*s +: 10]);
      F_CR: return int'(bus.X_Coin_R[10*s +: 10]);
      F_YC: return int'(bus.Y_Coin[10*s +: 10]);
      F_SH: return int'(bus.shift_Coin);
      F_SC: return int'(bus.score_pulse);
      default: return int'(bus.lfsr_out);
    endcase
  endfunction

  // Monitor: compare every expectation due at or before this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      ma = actual(me.fld, me.slot);
      vectors++;
      if (ma !== me.val) begin
        miscompares++;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", me.name, cyc, ma, me.val);
      end
    end
  end

  task automatic push(input string nm, input int f, input int s, input int v);
    exp_t e;
    e.cyc = cyc + 1; e.fld = f; e.slot = s; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic t, input logic rn, input logic [2:0] sp);
    @(posedge clk);
    #1;
    rst = r; bus.tick = t; bus.run = rn; bus.speed = sp;
  endtask

  task automatic push_pulses(input int sh, input int sc);
    push("shift_Coin", F_SH, 0, sh);
    push("score_pulse", F_SC, 0, sc);
  endtask

  initial begin
    bus.tick = 1'b0; bus.run = 1'b0; bus.speed = 3'd0;

    // Reset state
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    push("rst_s0_XL", F_XL, 0, 485);
    push("rst_s0_XR", F_XR, 0, 484);
    push("rst_s0_YT", F_YT, 0, 180);
    push("rst_s0_YB", F_YB, 0, 300);
    push("rst_s0_YC", F_YC, 0, 230);
    push("rst_s0_CL", F_CL, 0, 495);
    push("rst_s0_CR", F_CR, 0, 484);
    push("rst_s4_XL", F_XL, 4, 805);
    push("rst_s4_XR", F_XR, 4, 484);
    push("rst_lfsr", F_LF, 0, 16'hACE1);
    push_pulses(0, 0);
    drive(0, 0, 0, 0);
    push("lfsr_step1", F_LF, 0, 16'h5670);
    drive(0, 0, 0, 0);
    push("lfsr_step2", F_LF, 0, 16'hAB38);

    // Scroll at speed 5 through score and first recycle
    k = 0;
    repeat (74) begin
      drive(0, 1, 1, 5);
      k++;
      mv = m;
      push_pulses((k == 74) ? 1 : 0, (k == 65) ? 1 : 0);
      if (k == 10) begin
        push("t10_s0_XL", F_XL, 0, 435);
        push("t10_s0_XR", F_XR, 0, 474);
        push("t10_s0_CL", F_CL, 0, 445);
        push("t10_s0_CR", F_CR, 0, 464);
      end
      if (k == 65) push("t65_s0_XR", F_XR, 0, 199);
      if (k == 70) begin
        push("t70_s0_XL_clamp", F_XL, 0, 155);
        push("t70_s0_XR", F_XR, 0, 174);
        push("t70_s0_CL_clamp", F_CL, 0, 155);
        push("t70_s0_CR", F_CR, 0, 164);
      end
      if (k == 74) begin
        push("t74_s0_XL", F_XL, 0, 515);
        push("t74_s0_XR", F_XR, 0, 484);
        push("t74_s4_XL", F_XL, 4, 435);
        push("t74_s0_YT", F_YT, 0, 60 + int'(mv[7:0]));
        push("t74_s0_YB", F_YB, 0, 180 + int'(mv[7:0]));
        push("t74_s0_YC", F_YC, 0, 110 + int'(mv[7:0]));
        push("t74_lfsr", F_LF, 0, int'(lnext(mv)));
      end
    end

    // Hold: tick without run, run without tick, speed zero
    for (int ph = 0; ph < 3; ph++) begin
      repeat (3) begin
        case (ph)
          0:       drive(0, 1, 0, 5);
          1:       drive(0, 0, 1, 5);
          default: drive(0, 1, 1, 0);
        endcase
        mv = m;
        push_pulses(0, 0);
        push("hold_s0_XL", F_XL, 0, 515);
        push("hold_s4_XL", F_XL, 4, 435);
        push("hold_lfsr", F_LF, 0, int'(lnext(mv)));
      end
    end

    // Reset coinciding with a recycling tick
    drive(1, 0, 0, 0);
    k = 0;
    repeat (73) begin
      drive(0, 1, 1, 5);
      k++;
      push_pulses(0, (k == 65) ? 1 : 0);
    end
    drive(1, 1, 1, 5);
    push("rstrec_s0_XL", F_XL, 0, 485);
    push("rstrec_s0_YT", F_YT, 0, 180);
    push("rstrec_s4_XL", F_XL, 4, 805);
    push("rstrec_lfsr", F_LF, 0, 16'hACE1);
    push_pulses(0, 0);
    drive(0, 0, 0, 0);
    push("post_lfsr", F_LF, 0, 16'h5670);
    drive(0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Upstream world-state generator for the display selector stage.
- Owns five pipe slots scrolling right-to-left across the 330-pixel play field (x 155..484).
- Recycles each slot that leaves the left edge back to the right with a new pseudo-random gap.
- Produces the pipe edge, gap and coin coordinates the display selector draws, plus `shift_Coin` and score pulses for game control.

Parameters:
SCREEN_L, 155, left x of play field
SCREEN_R, 485, first x right of play field
PIPE_W, 40, pipe width in pixels
SPACING, 80, x distance between consecutive slots (must exceed 7)
GAP_H, 120, vertical gap height
GAP_MIN, 60, minimum gap top y
COIN_W, 20, coin square size
BIRD_X_L, 200, bird left x used for score detection
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk_100MHz  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle game-step strobe (once per frame)
run  in  1  scrolling enable
speed  in  3  pixels moved per tick (0..7)
X_Edge_L  out  50  slot i clamped pipe left x at [10i+9:10i]
X_Edge_R  out  50  slot i clamped pipe right x
Y_Edge_Top  out  50  slot i gap top y (top pipe ends here)
Y_Edge_Bottom  out  50  slot i gap bottom y (bottom pipe starts here)
X_Coin_L  out  50  slot i clamped coin left x
X_Coin_R  out  50  slot i clamped coin right x
Y_Coin  out  50  slot i coin top y
shift_Coin  out  1  one-cycle pulse on slot recycle
score_pulse  out  1  one-cycle pulse when a pipe passes the bird
lfsr_out  out  16  current LFSR state (debug/bench)

Behaviour:
- **Reset state:**
  - Slot i raw `xl[i] = SCREEN_R + i*SPACING` (485, 565, 645, 725, 805).
  - `yt[i] = 180`.
  - Rightmost pointer = 4.
  - LFSR = SEED.
  - `shift_Coin` = 0, `score_pulse` = 0.
  - All outputs reflect these values the cycle after `rst` is sampled.
  - `rst` wins over every other input, including mid-operation.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, advances every non-reset cycle regardless of `run`/`tick`.
- **Step:** occurs on a cycle with `tick & run`. `tick` without `run`, or `run` without `tick`, holds all positions.
- **Per slot per step:**
  - Recycle condition: `xl + PIPE_W - 1 < SCREEN_L + speed`, i.e. the pipe is fully left of the field after the move, evaluated on pre-move values.
  - If recycling: `xl <= xl[rightmost] - speed + SPACING`, and `yt <= GAP_MIN + lfsr[7:0]` (range 60..315). The rightmost pointer moves to this slot.
  - Otherwise: `xl <= xl - speed`.
- **Recycle limits:** at most one slot recycles per step, since SPACING > 7. `shift_Coin` pulses exactly one cycle, registered with the position update.
- **Score:** `score_pulse` = 1 for one cycle if any slot has pre-move `xl + PIPE_W - 1 >= BIRD_X_L` and post-move value `< BIRD_X_L`.
- **Derived outputs** (registered, same cycle as state update; all arithmetic 11-bit internally, 10-bit outputs):
  - Raw pipe right `xr = xl + PIPE_W - 1`.
  - `X_Edge_L = max(xl, SCREEN_L)`.
  - `X_Edge_R = min(xr, SCREEN_R - 1)`.
  - A slot wholly right of the field yields L > R, so nothing is drawn.
  - `Y_Edge_Top = yt`; `Y_Edge_Bottom = yt + GAP_H`.
  - Coin raw left = `xl + (PIPE_W - COIN_W)/2`; raw right = raw left + COIN_W - 1. Both are clamped the same way as the pipe edges.
  - `Y_Coin = yt + (GAP_H - COIN_W)/2`.
- **Latency:** one cycle from the `tick` edge to updated outputs.
- **`speed = 0`:** no movement, no recycle, no pulses.

Test Plan:
1. Assert `rst` 2 cycles -> slot0 `X_Edge_L` = 485, `X_Edge_R` = 484, `Y_Edge_Top` = 180, `Y_Edge_Bottom` = 300, `Y_Coin` = 230; slot4 `X_Edge_L` = 805; `lfsr_out` = 16'hACE1.
2. `run` = 1, `speed` = 5, 10 ticks -> slot0 `X_Edge_L` = 435, `X_Edge_R` = 474, `X_Coin_L` = 445, `X_Coin_R` = 464; no pulses.
3. `speed` = 5, 65 ticks from reset -> `score_pulse` high exactly one cycle after the 65th tick (slot0 raw `xr` 204 -> 199), with no other `score_pulse` during these 65 ticks.
4. `speed` = 5, 74 ticks from reset -> `shift_Coin` pulses once after tick 74. Slot0 raw `xl` = 515 (slot4 = 435), `Y_Edge_Top` = 60 + lfsr[7:0] sampled that cycle, and `Y_Edge_Bottom` = top + 120.
5. `tick` pulses with `run` = 0, then with `speed` = 0 -> all positions unchanged and no pulses, while `lfsr_out` keeps advancing.
6. `rst` asserted on the same cycle as a recycling tick -> reset values appear and `shift_Coin` stays 0.
